// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths and the packer state type for the Hamming(7,4)
// nibble packer.
//   NIBBLE_W  corrected data nibble width from the decoder
//   SYN_W     decoder syndrome width ({s1,s2,s3}, 000 = no error)
//   BYTE_W    packed output byte width
//   CNT_W     error counter width
package hamming_pkg;

  localparam int NIBBLE_W = 4;
  localparam int SYN_W    = 3;
  localparam int BYTE_W   = 8;
  localparam int CNT_W    = 16;

  // HALF0: no nibble held. HALF1: first nibble and its error flag held.
  typedef enum logic {
    HALF0 = 1'b0,
    HALF1 = 1'b1
  } pack_state_e;

  // A nibble is flagged whenever the decoder reported any syndrome bit.
  function automatic logic syn_is_err(input logic [SYN_W-1:0] syn);
    return |syn;
  endfunction

endpackage

// File: rtl/hamming_sync_fifo.sv
// hamming_sync_fifo: first-word-fall-through synchronous FIFO.
// Ports:
//   clk, rst   single clock, synchronous active-high reset
//   push_i     write wdata_i (ignored when full)
//   wdata_i    write data
//   pop_i      drop head entry (ignored when empty)
//   full_o     no free entry
//   empty_o    no entry stored
//   rdata_o    head entry, read straight from the storage registers
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
module hamming_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/hamming_nibble_packer.sv
// hamming_nibble_packer: packs corrected nibbles from a Hamming(7,4) decoder
// into bytes, tags each byte with an error flag, buffers bytes in a FIFO and
// counts flagged nibbles.
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   in_valid     decoded nibble present
//   in_ready     packer accepts a nibble this cycle
//   in_nibble    corrected data nibble
//   in_syndrome  decoder syndrome, 000 = no error
//   out_valid    byte available at FIFO head
//   out_ready    consumer takes the byte
//   out_byte     packed byte
//   out_err      at least one nibble of out_byte had a nonzero syndrome
//   cnt_clr      synchronous clear of err_count (wins over an increment)
//   err_count    saturating count of accepted flagged nibbles
//   dbg_state    packer FSM state (0 = HALF0, 1 = HALF1)
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds data stable while valid is high and ready is low.
module hamming_nibble_packer
  import hamming_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LOW_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] in_nibble,
  input  logic [SYN_W-1:0]    in_syndrome,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BYTE_W-1:0]   out_byte,
  output logic                out_err,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    err_count,
  output logic                dbg_state
);

  pack_state_e         state_q;
  logic [NIBBLE_W-1:0] nib_q;
  logic                flag_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                in_xfer;
  logic                new_err;
  logic                push;
  logic                fifo_full;
  logic                fifo_empty;
  logic [BYTE_W-1:0]   push_byte;
  logic [BYTE_W:0]     fifo_rdata;

  // in_ready depends only on local state and FIFO fullness, never on
  // out_ready, so a same-cycle pop does not open the input.
  assign in_ready = !rst && ((state_q == HALF0) || !fifo_full);
  assign in_xfer  = in_valid && in_ready;
  assign new_err  = syn_is_err(in_syndrome);
  assign push     = in_xfer && (state_q == HALF1);

  assign push_byte = (LOW_FIRST != 0) ? {in_nibble, nib_q} : {nib_q, in_nibble};

  hamming_sync_fifo #(
    .WIDTH (BYTE_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({flag_q | new_err, push_byte}),
    .pop_i   (out_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .rdata_o (fifo_rdata)
  );

  assign out_valid = !fifo_empty;
  assign out_err   = fifo_rdata[BYTE_W];
  assign out_byte  = fifo_rdata[BYTE_W-1:0];
  assign err_count = cnt_q;
  assign dbg_state = (state_q == HALF1);

  // Packer FSM: the second nibble goes straight into the FIFO together with
  // the held one, so the held registers are only meaningful in HALF1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HALF0;
      nib_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      case (state_q)
        HALF0: begin
          if (in_xfer) begin
            nib_q   <= in_nibble;
            flag_q  <= new_err;
            state_q <= HALF1;
          end
        end
        HALF1: begin
          if (in_xfer) begin
            nib_q   <= '0;
            flag_q  <= 1'b0;
            state_q <= HALF0;
          end
        end
        default: state_q <= HALF0;
      endcase
    end
  end

  // Error counter: clear beats increment; increment saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_q <= '0;
    end else if (in_xfer && new_err && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
